bp_controller: RTL and testbench
================================

# bp_controller

Control and update stage that sits directly upstream of `bp_cache` in the branch predictor. It turns fetch-stage branch PCs into taken/not-taken guesses and turns execute-stage branch outcomes into 2-bit saturating-counter updates. It drives both `bp_cache` read ports and its write port, and consumes `bp_cache` hit and data. Updates are registered one cycle, with forwarding so back-to-back branches see the newest counter. The block also keeps branch and mispredict statistics.

## Interface
- `AWIDTH`, 32, PC / cache address width
- `CWIDTH`, 2, saturating counter width; must equal `bp_cache` DWIDTH
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, synchronous, active-high
- `pc_guess` in AWIDTH, fetch-stage PC
- `is_br_guess` in 1, fetch-stage instruction is a conditional branch
- `br_taken_guess` out 1, predicted direction (combinational)
- `pc_check` in AWIDTH, execute-stage branch PC
- `is_br_check` in 1, execute-stage branch resolves this cycle
- `br_taken_check` in 1, actual direction
- `ra0` out AWIDTH, cache read port 0 address (= `pc_guess`)
- `dout0` in CWIDTH, cache port 0 data
- `hit0` in 1, cache port 0 hit
- `ra1` out AWIDTH, cache read port 1 address (= `pc_check`)
- `dout1` in CWIDTH, cache port 1 data
- `hit1` in 1, cache port 1 hit
- `wa` out AWIDTH, cache write address
- `din` out CWIDTH, cache write data
- `we` out 1, cache write enable
- `num_branches` out 32, resolved branches since reset
- `num_mispredicts` out 32, mispredicted branches since reset

## Operation
- Cache reads are asynchronous. Writes commit at the rising edge while `we` = 1.
- Pending-write register `{p_valid, p_addr, p_cnt}`. On each edge it loads `{is_br_check, pc_check, next_cnt}`.
- Outputs are driven from the register: `we` = `p_valid`, `wa` = `p_addr`, `din` = `p_cnt`.
- Effective check counter, in priority order:
  - `p_cnt` if `p_valid` and `p_addr` == `pc_check`;
  - else `dout1` if `hit1`;
  - else miss.
- Effective guess counter: the same rule with `pc_guess` and `dout0`/`hit0`.
- `br_taken_guess` = `is_br_guess` and effective guess counter is present and its MSB = 1. A miss predicts not-taken.
- `next_cnt`:
  - on a miss: 2'b10 if taken, else 2'b01 (weak init);
  - on a hit: counter +1 if taken, −1 if not, saturating at 2'b11 and 2'b00. No wrap.
- Mispredict at check: taken ≠ check-time predicted direction. A miss counts as a not-taken prediction.
- Stat counters:
  - `num_branches` += 1 on each edge with `is_br_check`;
  - `num_mispredicts` += 1 when that check is also a mispredict.
  - Both are 32-bit and wrap modulo 2^32.
- Simultaneous guess and check on the same PC: the guess uses the pre-update counter. The check's update is not forwarded to the same-cycle guess.

## Timing
- Guess: 0-cycle latency from `pc_guess` to `br_taken_guess`.
- A check in cycle N produces `we` = 1 in cycle N+1. The cache holds the new value from cycle N+2.
- The check in cycle N+1 sees the cycle-N update via forwarding. Consecutive checks to one PC therefore saturate correctly: T,T,T from 2'b01 writes 10, 11, 11.
- Reset values: `p_valid` = 0, so `we` = 0. `wa`/`din` = 0, `num_branches` = 0, `num_mispredicts` = 0.
- Reset in cycle N drops any pending write (it is not written) and ignores a check presented in cycle N.
- `br_taken_guess` is combinational. During reset it reflects the cache contents with no forwarding.
- No backpressure: exactly one update per check, and the write port is always free.

## Structure
- Package `bp_pkg` holds:
  - `CWIDTH`;
  - constants `BP_WEAK_T` = 2'b10, `BP_WEAK_NT` = 2'b01, `BP_SAT_MAX`, `BP_SAT_MIN`;
  - typedef `bp_cnt_t`.
- Sub-module `bp_sat_update`: combinational function of (hit, cnt, taken) returning next_cnt. Unit-tested separately.
- `bp_controller` holds the pending-write register, both forwarding muxes and the stat counters.
- `bp_controller` plus `bp_cache` are instantiated side by side in the predictor top.

## Test plan
- Reset, then a guess at PC 0x100 with the cache empty:
  - `br_taken_guess` = 0 and `we` = 0;
  - stats read 0.
- Check 0x100 taken (miss):
  - next cycle `we` = 1, `wa` = 0x100, `din` = 2'b10;
  - two cycles later a guess at 0x100 returns 1;
  - `num_mispredicts` = 1.
- Checks at 0x200 on consecutive cycles, pattern T,T,T,N:
  - `din` sequence 10, 11, 11, 10, which exercises forwarding and saturation;
  - `num_branches` = 4.
- Checks N,N,N at 0x300 from a miss:
  - `din` sequence 01, 00, 00, with no underflow;
  - mispredicts += 0.
- Same cycle: guess and check at 0x400 with counter 01, check taken:
  - guess = 0 that cycle, `din` = 10;
  - guess the cycle after (forwarded) = 1.
- Assert `reset` while `p_valid` = 1: no write occurs, stats clear to 0, and the next check proceeds normally.

Source files
------------

// File: rtl/bp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared counter width, counter type and saturating-counter
//             constants for the branch predictor control path.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Width of one saturating direction counter (matches bp_cache DWIDTH).
    localparam int CWIDTH = 2;

    typedef logic [CWIDTH-1:0] bp_cnt_t;

    // Initial values written on a first-time (missing) branch.
    localparam bp_cnt_t BP_WEAK_T  = 2'b10;
    localparam bp_cnt_t BP_WEAK_NT = 2'b01;

    // Saturation limits.
    localparam bp_cnt_t BP_SAT_MAX = 2'b11;
    localparam bp_cnt_t BP_SAT_MIN = 2'b00;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_update.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bp_sat_update
//  Purpose  : Combinational next-state function of a 2-bit saturating
//             direction counter.
//  Ports    : hit      - counter is present (cache hit or forwarded)
//             cnt      - current counter value (ignored on a miss)
//             taken    - resolved branch direction
//             next_cnt - counter value to write back
//  Revision : 1.0 - initial release
// ============================================================================
module bp_sat_update
    import bp_pkg::*;
(
    input  logic    hit,
    input  bp_cnt_t cnt,
    input  logic    taken,
    output bp_cnt_t next_cnt
);

    always_comb begin
        next_cnt = BP_WEAK_NT;
        if (!hit) begin
            // First sighting of this branch: start at the weak state
            // pointing in the direction just observed.
            next_cnt = taken ? BP_WEAK_T : BP_WEAK_NT;
        end else if (taken) begin
            next_cnt = (cnt == BP_SAT_MAX) ? cnt : cnt + bp_cnt_t'(1);
        end else begin
            next_cnt = (cnt == BP_SAT_MIN) ? cnt : cnt - bp_cnt_t'(1);
        end
    end

endmodule : bp_sat_update
`default_nettype wire

// File: rtl/bp_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bp_controller
//  Purpose  : Control/update stage in front of bp_cache. Produces fetch-stage
//             taken/not-taken guesses and registers one counter update per
//             resolved branch, forwarding the pending update so back-to-back
//             branches see the newest counter. Keeps branch statistics.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             pc_guess, is_br_guess      - fetch-stage branch lookup
//             br_taken_guess             - predicted direction (comb.)
//             pc_check, is_br_check,
//             br_taken_check             - execute-stage branch outcome
//             ra0/dout0/hit0             - cache read port 0 (guess)
//             ra1/dout1/hit1             - cache read port 1 (check)
//             wa/din/we                  - cache write port
//             num_branches,
//             num_mispredicts            - statistics since reset
//  Revision : 1.0 - initial release
// ============================================================================
module bp_controller #(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = bp_pkg::CWIDTH
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [AWIDTH-1:0] pc_guess,
    input  logic              is_br_guess,
    output logic              br_taken_guess,

    input  logic [AWIDTH-1:0] pc_check,
    input  logic              is_br_check,
    input  logic              br_taken_check,

    output logic [AWIDTH-1:0] ra0,
    input  logic [CWIDTH-1:0] dout0,
    input  logic              hit0,

    output logic [AWIDTH-1:0] ra1,
    input  logic [CWIDTH-1:0] dout1,
    input  logic              hit1,

    output logic [AWIDTH-1:0] wa,
    output logic [CWIDTH-1:0] din,
    output logic              we,

    output logic [31:0]       num_branches,
    output logic [31:0]       num_mispredicts
);

    // Pending-write register and statistics
    logic              p_valid_q, p_valid_d;
    logic [AWIDTH-1:0] p_addr_q,  p_addr_d;
    logic [CWIDTH-1:0] p_cnt_q,   p_cnt_d;
    logic [31:0]       num_branches_q,    num_branches_d;
    logic [31:0]       num_mispredicts_q, num_mispredicts_d;

    // Forwarding / prediction wires
    logic              w_fwd_check;
    logic              w_check_hit;
    logic [CWIDTH-1:0] w_check_cnt;
    logic              w_check_pred;
    logic              w_fwd_guess;
    logic              w_guess_hit;
    logic [CWIDTH-1:0] w_guess_cnt;
    logic              w_mispredict;
    logic [CWIDTH-1:0] w_next_cnt;

    assign ra0 = pc_guess;
    assign ra1 = pc_check;

    // The pending register holds the newest counter for p_addr; the cache
    // copy is one update stale until the write commits.
    always_comb begin
        w_fwd_check  = p_valid_q && (p_addr_q == pc_check);
        w_check_hit  = w_fwd_check || hit1;
        w_check_cnt  = w_fwd_check ? p_cnt_q : dout1;
        w_check_pred = w_check_hit && w_check_cnt[CWIDTH-1];
        w_mispredict = is_br_check && (br_taken_check != w_check_pred);
    end

    // Guess forwarding is suppressed during reset so the guess reflects
    // only what is actually in the cache. A same-cycle check never reaches
    // the guess: only the already-registered update is forwarded.
    always_comb begin
        w_fwd_guess    = !reset && p_valid_q && (p_addr_q == pc_guess);
        w_guess_hit    = w_fwd_guess || hit0;
        w_guess_cnt    = w_fwd_guess ? p_cnt_q : dout0;
        br_taken_guess = is_br_guess && w_guess_hit && w_guess_cnt[CWIDTH-1];
    end

    bp_sat_update u_sat_update (
        .hit      (w_check_hit),
        .cnt      (w_check_cnt),
        .taken    (br_taken_check),
        .next_cnt (w_next_cnt)
    );

    always_comb begin
        p_valid_d         = is_br_check;
        p_addr_d          = pc_check;
        p_cnt_d           = w_next_cnt;
        num_branches_d    = num_branches_q    + {31'b0, is_br_check};
        num_mispredicts_d = num_mispredicts_q + {31'b0, w_mispredict};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid_q         <= 1'b0;
            p_addr_q          <= '0;
            p_cnt_q           <= '0;
            num_branches_q    <= '0;
            num_mispredicts_q <= '0;
        end else begin
            p_valid_q         <= p_valid_d;
            p_addr_q          <= p_addr_d;
            p_cnt_q           <= p_cnt_d;
            num_branches_q    <= num_branches_d;
            num_mispredicts_q <= num_mispredicts_d;
        end
    end

    // A write still pending when reset is raised must not reach the cache:
    // the cache would otherwise commit it on the same edge that clears us.
    assign we              = p_valid_q && !reset;
    assign wa              = p_addr_q;
    assign din             = p_cnt_q;
    assign num_branches    = num_branches_q;
    assign num_mispredicts = num_mispredicts_q;

endmodule : bp_controller
`default_nettype wire

// File: tb/tb_bp_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bp_controller
//  Purpose  : Directed self-checking bench for bp_controller, with a small
//             behavioural model of bp_cache attached to its ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        br_taken_guess;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;
    logic [31:0] ra0, ra1, wa;
    logic [1:0]  dout0, dout1, din;
    logic        hit0, hit1, we;
    logic [31:0] num_branches, num_mispredicts;

    int tests_run    = 0;
    int tests_failed = 0;

    bp_controller #(.AWIDTH(32), .CWIDTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_guess        (pc_guess),
        .is_br_guess     (is_br_guess),
        .br_taken_guess  (br_taken_guess),
        .pc_check        (pc_check),
        .is_br_check     (is_br_check),
        .br_taken_check  (br_taken_check),
        .ra0             (ra0),
        .dout0           (dout0),
        .hit0            (hit0),
        .ra1             (ra1),
        .dout1           (dout1),
        .hit1            (hit1),
        .wa              (wa),
        .din             (din),
        .we              (we),
        .num_branches    (num_branches),
        .num_mispredicts (num_mispredicts)
    );

    // Cache model: 16 direct-mapped entries indexed by address bits [11:8],
    // asynchronous read, write on the rising edge while we = 1.
    logic        c_valid [16];
    logic [31:0] c_tag   [16];
    logic [1:0]  c_data  [16];
    logic        cache_clr;

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < 16; i++) c_valid[i] <= 1'b0;
        end else if (we) begin
            c_valid[wa[11:8]] <= 1'b1;
            c_tag[wa[11:8]]   <= wa;
            c_data[wa[11:8]]  <= din;
        end
    end

    always_comb begin
        hit0  = c_valid[ra0[11:8]] && (c_tag[ra0[11:8]] == ra0);
        dout0 = c_data[ra0[11:8]];
        hit1  = c_valid[ra1[11:8]] && (c_tag[ra1[11:8]] == ra1);
        dout1 = c_data[ra1[11:8]];
    end

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_200   [4];
    logic       taken_200 [4];
    logic [1:0] exp_300   [3];

    initial begin
        exp_200   = '{2'b10, 2'b11, 2'b11, 2'b10};
        taken_200 = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_300   = '{2'b01, 2'b00, 2'b00};

        reset = 1'b1; cache_clr = 1'b1;
        pc_guess = '0; is_br_guess = 1'b0;
        pc_check = '0; is_br_check = 1'b0; br_taken_check = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tb_check("rst_we", {31'b0, we}, 32'd0);
        tb_check("rst_nb", num_branches, 32'd0);
        reset = 1'b0; cache_clr = 1'b0;

        // Empty cache guess
        pc_guess = 32'h100; is_br_guess = 1'b1;
        #1;
        tb_check("empty_guess", {31'b0, br_taken_guess}, 32'd0);
        tb_check("empty_we",    {31'b0, we}, 32'd0);
        tb_check("empty_wa",    wa, 32'd0);
        tb_check("empty_din",   {30'b0, din}, 32'd0);
        tb_check("empty_nb",    num_branches, 32'd0);
        tb_check("empty_nm",    num_mispredicts, 32'd0);

        // Check 0x100 taken on a miss
        is_br_guess = 1'b0;
        pc_check = 32'h100; is_br_check = 1'b1; br_taken_check = 1'b1;
        tick();
        is_br_check = 1'b0;
        #1;
        tb_check("c100_we",  {31'b0, we}, 32'd1);
        tb_check("c100_wa",  wa, 32'h100);
        tb_check("c100_din", {30'b0, din}, 32'd2);
        tb_check("c100_nb",  num_branches, 32'd1);
        tb_check("c100_nm",  num_mispredicts, 32'd1);
        tick();
        pc_guess = 32'h100; is_br_guess = 1'b1;
        #1;
        tb_check("g100_guess", {31'b0, br_taken_guess}, 32'd1);
        tb_check("g100_we",    {31'b0, we}, 32'd0);
        is_br_guess = 1'b0;

        // 0x200 T,T,T,N back to back
        for (int i = 0; i < 4; i++) begin
            pc_check = 32'h200; is_br_check = 1'b1; br_taken_check = taken_200[i];
            tick();
            tb_check("c200_we",  {31'b0, we}, 32'd1);
            tb_check("c200_wa",  wa, 32'h200);
            tb_check("c200_din", {30'b0, din}, {30'b0, exp_200[i]});
        end
        is_br_check = 1'b0;
        #1;
        tb_check("c200_nb", num_branches, 32'd5);
        tb_check("c200_nm", num_mispredicts, 32'd3);

        // 0x300 N,N,N from a miss
        for (int i = 0; i < 3; i++) begin
            pc_check = 32'h300; is_br_check = 1'b1; br_taken_check = 1'b0;
            tick();
            tb_check("c300_din", {30'b0, din}, {30'b0, exp_300[i]});
        end
        is_br_check = 1'b0;
        #1;
        tb_check("c300_nb", num_branches, 32'd8);
        tb_check("c300_nm", num_mispredicts, 32'd3);

        // Establish 0x400 = 01 in the cache
        pc_check = 32'h400; is_br_check = 1'b1; br_taken_check = 1'b0;
        tick();
        tb_check("c400_init_din", {30'b0, din}, 32'd1);
        is_br_check = 1'b0;
        tick();
        // Same-cycle guess and check at 0x400
        pc_guess = 32'h400; is_br_guess = 1'b1;
        pc_check = 32'h400; is_br_check = 1'b1; br_taken_check = 1'b1;
        #1;
        tb_check("same_guess", {31'b0, br_taken_guess}, 32'd0);
        tick();
        is_br_check = 1'b0;
        #1;
        tb_check("same_din",   {30'b0, din}, 32'd2);
        tb_check("same_wa",    wa, 32'h400);
        tb_check("fwd_guess",  {31'b0, br_taken_guess}, 32'd1);
        tb_check("same_nb",    num_branches, 32'd10);
        tb_check("same_nm",    num_mispredicts, 32'd4);
        is_br_guess = 1'b0;

        // Reset while a write is pending
        pc_check = 32'h500; is_br_check = 1'b1; br_taken_check = 1'b1;
        tick();
        tb_check("pend_we", {31'b0, we}, 32'd1);
        reset = 1'b1;
        pc_check = 32'h600;
        pc_guess = 32'h500; is_br_guess = 1'b1;
        #1;
        tb_check("rstp_we",    {31'b0, we}, 32'd0);
        tb_check("rstp_guess", {31'b0, br_taken_guess}, 32'd0);
        tick();
        reset = 1'b0; is_br_check = 1'b0;
        #1;
        tb_check("post_rst_we",    {31'b0, we}, 32'd0);
        tb_check("post_rst_nb",    num_branches, 32'd0);
        tb_check("post_rst_nm",    num_mispredicts, 32'd0);
        tb_check("post_rst_guess", {31'b0, br_taken_guess}, 32'd0);
        is_br_guess = 1'b0;
        pc_check = 32'h500; is_br_check = 1'b1; br_taken_check = 1'b1;
        tick();
        is_br_check = 1'b0;
        #1;
        tb_check("after_we",  {31'b0, we}, 32'd1);
        tb_check("after_wa",  wa, 32'h500);
        tb_check("after_din", {30'b0, din}, 32'd2);
        tb_check("after_nb",  num_branches, 32'd1);
        tb_check("after_nm",  num_mispredicts, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_bp_controller
`default_nettype wire
